swoop_enemy_array: RTL and testbench
====================================

SWOOP_ENEMY_ARRAY -- requirements
Module: swoop_enemy_array

Interface
REQ-001 Parameter NUM_ENEMIES, default 4: independent enemies, legal 1..8.
REQ-002 Parameter ENEMY_SIZE, default 30: sprite edge in pixels.
REQ-003 Parameter DIVE_PERIOD, default 128: HOVER frames before a dive.
REQ-004 Parameter RESPAWN_FRAMES, default 120: DEAD frames before respawn.
REQ-005 Parameter HOVER_DY, default 100: hover height above player, pixels.
REQ-006 Parameter SLOW_STEP 2, FAST_STEP_X 6, FAST_STEP_Y 15, CLIMB_STEP 5: per-frame pixel speeds.
REQ-007 Parameter SCORE_W, default 8: score width.
REQ-008 Clk  in  1  single system clock; all logic is on its rising edge.
REQ-009 RESET_n  in  1  asynchronous, active-low reset.
REQ-010 frame_clk  in  1  vertical-sync level, asynchronous to nothing, sampled on Clk.
REQ-011 dead  in  1  player death; synchronous clear.
REQ-012 player_x, player_y  in  10 each  player top-left, pixels.
REQ-013 hit  in  NUM_ENEMIES  per-enemy collision pulse or level, any cycle.
REQ-014 enemy_x, enemy_y  out  10*NUM_ENEMIES each  enemy i at bits [10i+9:10i].
REQ-015 enemy_on  out  NUM_ENEMIES  enemy drawable.
REQ-016 diving  out  NUM_ENEMIES  enemy in DIVE.
REQ-017 score  out  SCORE_W  kill count.

Function
REQ-018 tick SHALL be a one-Clk pulse, registered, on each rising edge of frame_clk (frame_clk high and previous sample low); all motion and counters advance only on tick.
REQ-019 hit[i] SHALL set a sticky pending[i] on any cycle; pending[i] is cleared on the tick that consumes it, or ignored and cleared while enemy i is DEAD.
REQ-020 Each enemy SHALL run FSM HOVER/DIVE/RETREAT/DEAD; every transition occurs on tick; position updates on the same tick use the new state's velocity.
REQ-021 HOVER: dx = +SLOW_STEP if x+60 < player_x, -SLOW_STEP if x > player_x+120, else 0; dy = -CLIMB_STEP if y > player_y-HOVER_DY (target 0 when player_y < HOVER_DY), else 0; dive counter increments; at DIVE_PERIOD-1 -> DIVE, counter cleared.
REQ-022 DIVE: dy = +FAST_STEP_Y; dx = +FAST_STEP_X if player_x+30 > x+ENEMY_SIZE else -FAST_STEP_X; when y > player_y+30 -> RETREAT.
REQ-023 RETREAT: dy = -CLIMB_STEP, dx = ±SLOW_STEP toward player by the REQ-022 comparison; when y <= player_y-HOVER_DY or y == 0 -> HOVER.
REQ-024 Any live state with pending hit at tick SHALL go to DEAD (priority over all other transitions), enemy_on=0, respawn counter 0.
REQ-025 DEAD: no motion; respawn counter increments; at RESPAWN_FRAMES-1 -> HOVER at spawn position, enemy_on=1, dive counter restaged per REQ-029.
REQ-026 Position arithmetic SHALL use 12-bit signed intermediates and clamp x to [5, 635-ENEMY_SIZE], y to [0, 479-ENEMY_SIZE]; no wrap-around.
REQ-027 score SHALL increase on a tick by the number of enemies entering DEAD on that tick (simultaneous kills all count) and saturate at all-ones.
REQ-028 Spawn position of enemy i SHALL be x = 60+i*70, y = 40.
REQ-029 Dive counter of enemy i SHALL start at i*(DIVE_PERIOD/NUM_ENEMIES) so dives are staggered.
REQ-030 dead SHALL, on the next Clk, force every register to its reset value; dead has priority over tick.
REQ-031 diving[i] and enemy_on[i] SHALL be registered, decoded from state.

Reset
REQ-032 RESET_n low SHALL asynchronously set: all enemies HOVER at spawn, enemy_on all 1, diving all 0, pending 0, respawn counters 0, dive counters per REQ-029, score 0, tick 0, frame_clk sample 0.

Structure
REQ-033 Package swoop_pkg SHALL hold the state enum, screen bounds, spawn constants and the 12-bit clamp width.
REQ-034 Sub-module swoop_enemy_unit (one enemy: FSM, counters, pending, position) SHALL be instantiated NUM_ENEMIES times by generate; top holds tick detector and score adder.

Verification
REQ-035 Reset, 127 ticks, player (320,400), N=4: enemy 0 diving asserts on tick 128, enemy 1 on tick 96.
REQ-036 hit[2] one-cycle pulse mid-frame: next tick enemy_on[2]=0, score 0->1; after 120 further ticks enemy 2 reappears at (200,40).
REQ-037 hit[0] and hit[3] in same frame: score +2 on one tick.
REQ-038 Enemy at x=5 with leftward dx: x stays 5; score 255 plus one kill stays 255.
REQ-039 dead asserted mid-DIVE: next cycle all outputs equal reset values; RESET_n low mid-frame clears immediately without Clk.

Source files
------------

// File: rtl/swoop_pkg.sv
// rtl/swoop_pkg.sv - shared state type, screen bounds and spawn constants for the enemy array
package swoop_pkg;

  typedef enum logic [1:0] {
    ST_HOVER   = 2'd0,
    ST_DIVE    = 2'd1,
    ST_RETREAT = 2'd2,
    ST_DEAD    = 2'd3
  } enemy_state_t;

  // Signed width of all position arithmetic; wide enough that no step wraps.
  localparam int POS_W = 12;

  // Playfield bounds for the sprite's top-left corner (sprite size subtracted by the user).
  localparam int X_MIN  = 5;
  localparam int X_EDGE = 635;
  localparam int Y_MIN  = 0;
  localparam int Y_EDGE = 479;

  // Spawn layout: enemy i at (SPAWN_X0 + i*SPAWN_PITCH, SPAWN_Y).
  localparam int SPAWN_X0    = 60;
  localparam int SPAWN_PITCH = 70;
  localparam int SPAWN_Y     = 40;

  // Hover tracking dead-band and dive aim/exit offsets relative to the player.
  localparam int TRACK_LEFT  = 60;
  localparam int TRACK_RIGHT = 120;
  localparam int AIM_OFS     = 30;
  localparam int RETREAT_OFS = 30;

  // Saturate a signed position into [lo, hi].
  function automatic logic signed [POS_W-1:0] clamp_pos(
    input logic signed [POS_W-1:0] v,
    input int                      lo,
    input int                      hi
  );
    logic signed [POS_W-1:0] l;
    logic signed [POS_W-1:0] h;
    l = POS_W'(lo);
    h = POS_W'(hi);
    if (v < l) begin
      return l;
    end else if (v > h) begin
      return h;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/swoop_enemy_unit.sv
// rtl/swoop_enemy_unit.sv - one enemy: state machine, dive/respawn counters, hit latch, position
module swoop_enemy_unit
  import swoop_pkg::*;
#(
  parameter int IDX            = 0,
  parameter int NUM_ENEMIES    = 4,
  parameter int ENEMY_SIZE     = 30,
  parameter int DIVE_PERIOD    = 128,
  parameter int RESPAWN_FRAMES = 120,
  parameter int HOVER_DY       = 100,
  parameter int SLOW_STEP      = 2,
  parameter int FAST_STEP_X    = 6,
  parameter int FAST_STEP_Y    = 15,
  parameter int CLIMB_STEP     = 5
) (
  input  logic       Clk,
  input  logic       RESET_n,
  input  logic       i_clr,
  input  logic       i_tick,
  input  logic       i_hit,
  input  logic [9:0] i_player_x,
  input  logic [9:0] i_player_y,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_on,
  output logic       o_diving,
  output logic       o_kill
);

  localparam int DCW  = (DIVE_PERIOD > 1) ? $clog2(DIVE_PERIOD) : 1;
  localparam int RCW  = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam int X_HI = X_EDGE - ENEMY_SIZE;
  localparam int Y_HI = Y_EDGE - ENEMY_SIZE;

  // Staggered dive phase so the enemies do not all dive on the same frame.
  localparam logic [DCW-1:0] DIVE_INIT = DCW'(IDX * (DIVE_PERIOD / NUM_ENEMIES));
  localparam logic [DCW-1:0] DIVE_LAST = DCW'(DIVE_PERIOD - 1);
  localparam logic [RCW-1:0] RESP_LAST = RCW'(RESPAWN_FRAMES - 1);

  localparam logic signed [POS_W-1:0] SPAWN_XP   = POS_W'(SPAWN_X0 + IDX * SPAWN_PITCH);
  localparam logic signed [POS_W-1:0] SPAWN_YP   = POS_W'(SPAWN_Y);
  localparam logic signed [POS_W-1:0] K_SLOW     = POS_W'(SLOW_STEP);
  localparam logic signed [POS_W-1:0] K_FAST_X   = POS_W'(FAST_STEP_X);
  localparam logic signed [POS_W-1:0] K_FAST_Y   = POS_W'(FAST_STEP_Y);
  localparam logic signed [POS_W-1:0] K_CLIMB    = POS_W'(CLIMB_STEP);
  localparam logic signed [POS_W-1:0] K_HOVER_DY = POS_W'(HOVER_DY);
  localparam logic signed [POS_W-1:0] K_SIZE     = POS_W'(ENEMY_SIZE);
  localparam logic signed [POS_W-1:0] K_TRACK_L  = POS_W'(TRACK_LEFT);
  localparam logic signed [POS_W-1:0] K_TRACK_R  = POS_W'(TRACK_RIGHT);
  localparam logic signed [POS_W-1:0] K_AIM      = POS_W'(AIM_OFS);
  localparam logic signed [POS_W-1:0] K_RETREAT  = POS_W'(RETREAT_OFS);

  enemy_state_t            r_state;
  enemy_state_t            w_state_nxt;
  logic [DCW-1:0]          r_dive_cnt;
  logic [DCW-1:0]          w_dive_nxt;
  logic [RCW-1:0]          r_resp_cnt;
  logic [RCW-1:0]          w_resp_nxt;
  logic signed [POS_W-1:0] r_x;
  logic signed [POS_W-1:0] r_y;
  logic signed [POS_W-1:0] w_px;
  logic signed [POS_W-1:0] w_py;
  logic signed [POS_W-1:0] w_hover_tgt;
  logic signed [POS_W-1:0] w_dx;
  logic signed [POS_W-1:0] w_dy;
  logic signed [POS_W-1:0] w_x_nxt;
  logic signed [POS_W-1:0] w_y_nxt;
  logic                    r_pending;
  logic                    r_on;
  logic                    r_diving;
  logic                    w_hit_now;
  logic                    w_kill;
  logic                    w_respawn;
  logic                    w_aim_right;

  assign w_px        = {2'b00, i_player_x};
  assign w_py        = {2'b00, i_player_y};
  // A hit arriving on the tick cycle itself is honoured, not deferred a frame.
  assign w_hit_now   = r_pending | i_hit;
  // Hover altitude target, floored at the top of the screen.
  assign w_hover_tgt = (w_py < K_HOVER_DY) ? '0 : (w_py - K_HOVER_DY);
  assign w_aim_right = (w_px + K_AIM) > (r_x + K_SIZE);

  // Next state and counters; only a tick moves anything, and a kill beats every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_dive_nxt  = r_dive_cnt;
    w_resp_nxt  = r_resp_cnt;
    w_kill      = 1'b0;
    w_respawn   = 1'b0;
    if (i_tick) begin
      if ((r_state != ST_DEAD) && w_hit_now) begin
        w_state_nxt = ST_DEAD;
        w_resp_nxt  = '0;
        w_kill      = 1'b1;
      end else begin
        case (r_state)
          ST_HOVER: begin
            if (r_dive_cnt == DIVE_LAST) begin
              w_state_nxt = ST_DIVE;
              w_dive_nxt  = '0;
            end else begin
              w_dive_nxt = r_dive_cnt + DCW'(1);
            end
          end
          ST_DIVE: begin
            if (r_y > (w_py + K_RETREAT)) begin
              w_state_nxt = ST_RETREAT;
            end
          end
          ST_RETREAT: begin
            if ((r_y <= w_hover_tgt) || (r_y == '0)) begin
              w_state_nxt = ST_HOVER;
            end
          end
          default: begin
            if (r_resp_cnt == RESP_LAST) begin
              w_state_nxt = ST_HOVER;
              w_dive_nxt  = DIVE_INIT;
              w_resp_nxt  = '0;
              w_respawn   = 1'b1;
            end else begin
              w_resp_nxt = r_resp_cnt + RCW'(1);
            end
          end
        endcase
      end
    end
  end

  // Velocity chosen by the state being entered, then clamped into the playfield.
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    case (w_state_nxt)
      ST_HOVER: begin
        if ((r_x + K_TRACK_L) < w_px) begin
          w_dx = K_SLOW;
        end else if (r_x > (w_px + K_TRACK_R)) begin
          w_dx = -K_SLOW;
        end
        if (r_y > w_hover_tgt) begin
          w_dy = -K_CLIMB;
        end
      end
      ST_DIVE: begin
        w_dy = K_FAST_Y;
        w_dx = w_aim_right ? K_FAST_X : -K_FAST_X;
      end
      ST_RETREAT: begin
        w_dy = -K_CLIMB;
        w_dx = w_aim_right ? K_SLOW : -K_SLOW;
      end
      default: begin
        w_dx = '0;
        w_dy = '0;
      end
    endcase
    w_x_nxt = clamp_pos(r_x + w_dx, X_MIN, X_HI);
    w_y_nxt = clamp_pos(r_y + w_dy, Y_MIN, Y_HI);
  end

  // State, counters, position and decoded flags; a player death restores the power-up values.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= ST_HOVER;
      r_dive_cnt <= DIVE_INIT;
      r_resp_cnt <= '0;
      r_x        <= SPAWN_XP;
      r_y        <= SPAWN_YP;
      r_on       <= 1'b1;
      r_diving   <= 1'b0;
    end else if (i_clr) begin
      r_state    <= ST_HOVER;
      r_dive_cnt <= DIVE_INIT;
      r_resp_cnt <= '0;
      r_x        <= SPAWN_XP;
      r_y        <= SPAWN_YP;
      r_on       <= 1'b1;
      r_diving   <= 1'b0;
    end else if (i_tick) begin
      r_state    <= w_state_nxt;
      r_dive_cnt <= w_dive_nxt;
      r_resp_cnt <= w_resp_nxt;
      r_on       <= (w_state_nxt != ST_DEAD);
      r_diving   <= (w_state_nxt == ST_DIVE);
      if (w_respawn) begin
        r_x <= SPAWN_XP;
        r_y <= SPAWN_YP;
      end else begin
        r_x <= w_x_nxt;
        r_y <= w_y_nxt;
      end
    end
  end

  // Sticky hit latch: consumed by every tick, and never armed while the enemy is dead.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_pending <= 1'b0;
    end else if (i_clr || i_tick || (r_state == ST_DEAD)) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= r_pending | i_hit;
    end
  end

  assign o_x      = r_x[9:0];
  assign o_y      = r_y[9:0];
  assign o_on     = r_on;
  assign o_diving = r_diving;
  assign o_kill   = w_kill;

endmodule

// File: rtl/swoop_enemy_array.sv
// rtl/swoop_enemy_array.sv - frame tick detector, enemy instances and saturating kill score
module swoop_enemy_array
  import swoop_pkg::*;
#(
  parameter int NUM_ENEMIES    = 4,
  parameter int ENEMY_SIZE     = 30,
  parameter int DIVE_PERIOD    = 128,
  parameter int RESPAWN_FRAMES = 120,
  parameter int HOVER_DY       = 100,
  parameter int SLOW_STEP      = 2,
  parameter int FAST_STEP_X    = 6,
  parameter int FAST_STEP_Y    = 15,
  parameter int CLIMB_STEP     = 5,
  parameter int SCORE_W        = 8
) (
  input  logic                      Clk,
  input  logic                      RESET_n,
  input  logic                      frame_clk,
  input  logic                      dead,
  input  logic [9:0]                player_x,
  input  logic [9:0]                player_y,
  input  logic [NUM_ENEMIES-1:0]    hit,
  output logic [10*NUM_ENEMIES-1:0] enemy_x,
  output logic [10*NUM_ENEMIES-1:0] enemy_y,
  output logic [NUM_ENEMIES-1:0]    enemy_on,
  output logic [NUM_ENEMIES-1:0]    diving,
  output logic [SCORE_W-1:0]        score
);

  localparam int SUM_W = SCORE_W + 4;

  logic                   r_frame_q;
  logic                   r_tick;
  logic [NUM_ENEMIES-1:0] w_kill;
  logic [3:0]             w_kill_cnt;
  logic [SUM_W-1:0]       w_score_sum;
  logic [SCORE_W-1:0]     w_score_nxt;
  logic [SCORE_W-1:0]     r_score;

  // One-cycle tick on each rising edge of the vsync level.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_frame_q <= 1'b0;
      r_tick    <= 1'b0;
    end else if (dead) begin
      r_frame_q <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_frame_q <= frame_clk;
      r_tick    <= frame_clk & ~r_frame_q;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_ENEMIES; g++) begin : g_enemy
      swoop_enemy_unit #(
        .IDX            (g),
        .NUM_ENEMIES    (NUM_ENEMIES),
        .ENEMY_SIZE     (ENEMY_SIZE),
        .DIVE_PERIOD    (DIVE_PERIOD),
        .RESPAWN_FRAMES (RESPAWN_FRAMES),
        .HOVER_DY       (HOVER_DY),
        .SLOW_STEP      (SLOW_STEP),
        .FAST_STEP_X    (FAST_STEP_X),
        .FAST_STEP_Y    (FAST_STEP_Y),
        .CLIMB_STEP     (CLIMB_STEP)
      ) u_enemy (
        .Clk        (Clk),
        .RESET_n    (RESET_n),
        .i_clr      (dead),
        .i_tick     (r_tick),
        .i_hit      (hit[g]),
        .i_player_x (player_x),
        .i_player_y (player_y),
        .o_x        (enemy_x[10*g +: 10]),
        .o_y        (enemy_y[10*g +: 10]),
        .o_on       (enemy_on[g]),
        .o_diving   (diving[g]),
        .o_kill     (w_kill[g])
      );
    end
  endgenerate

  // Count simultaneous kills and add them, saturating at all-ones.
  always_comb begin
    w_kill_cnt = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      w_kill_cnt = w_kill_cnt + 4'(w_kill[i]);
    end
    w_score_sum = {4'b0000, r_score} + {{SCORE_W{1'b0}}, w_kill_cnt};
    w_score_nxt = (|w_score_sum[SUM_W-1:SCORE_W]) ? '1 : w_score_sum[SCORE_W-1:0];
  end

  // Score register, advanced only on a tick since kills only happen then.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_score <= '0;
    end else if (dead) begin
      r_score <= '0;
    end else if (r_tick) begin
      r_score <= w_score_nxt;
    end
  end

  assign score = r_score;

endmodule

// File: tb/tb_swoop_enemy_array.sv
// tb/tb_swoop_enemy_array.sv - self-checking bench for swoop_enemy_array
module tb_swoop_enemy_array;

  logic        Clk = 1'b0;
  logic        RESET_n;
  logic        frame_clk;
  logic        dead;
  logic [9:0]  player_x;
  logic [9:0]  player_y;
  logic [3:0]  hit;
  logic [39:0] enemy_x;
  logic [39:0] enemy_y;
  logic [3:0]  enemy_on;
  logic [3:0]  diving;
  logic [7:0]  score;

  int n_checks = 0;
  int n_fail   = 0;
  int tcount   = 0;

  typedef struct {
    bit rst;
    int px;
    int py;
    int t;
    int idx;
    int ex;
    int ey;
    int eon;
    int ediv;
    int escore;
  } vec_t;

  vec_t vecs[16];
  vec_t exp_q[$];

  always #5 Clk = ~Clk;

  swoop_enemy_array dut (
    .Clk       (Clk),
    .RESET_n   (RESET_n),
    .frame_clk (frame_clk),
    .dead      (dead),
    .player_x  (player_x),
    .player_y  (player_y),
    .hit       (hit),
    .enemy_x   (enemy_x),
    .enemy_y   (enemy_y),
    .enemy_on  (enemy_on),
    .diving    (diving),
    .score     (score)
  );

  function automatic int ex_of(input int i);
    return int'(enemy_x[10*i +: 10]);
  endfunction

  function automatic int ey_of(input int i);
    return int'(enemy_y[10*i +: 10]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    RESET_n   = 1'b0;
    frame_clk = 1'b0;
    dead      = 1'b0;
    hit       = 4'b0000;
    @(posedge Clk); #1;
    RESET_n = 1'b1;
    tcount  = 0;
  endtask

  task automatic do_tick();
    frame_clk = 1'b1;
    @(posedge Clk); #1;
    frame_clk = 1'b0;
    @(posedge Clk); #1;
    tcount++;
  endtask

  task automatic pulse_hit(input logic [3:0] m);
    hit = m;
    @(posedge Clk); #1;
    hit = 4'b0000;
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_x%0d", tag, i), ex_of(i), 60 + 70 * i);
      check($sformatf("%s_y%0d", tag, i), ey_of(i), 40);
    end
    check($sformatf("%s_on", tag), int'(enemy_on), 15);
    check($sformatf("%s_div", tag), int'(diving), 0);
    check($sformatf("%s_score", tag), int'(score), 0);
  endtask

  initial begin
    vec_t cur;

    // {rst, px, py, tick, idx, x, y, on, diving, score}
    vecs[0]  = '{1'b1, 320, 400,   1, 0,  62,  40, 1, 0, 0};
    vecs[1]  = '{1'b0, 320, 400,   1, 3, 270,  40, 1, 0, 0};
    vecs[2]  = '{1'b0, 320, 400,  30, 2, 260,  40, 1, 0, 0};
    vecs[3]  = '{1'b0, 320, 400,  31, 3, 270,  40, 1, 0, 0};
    vecs[4]  = '{1'b0, 320, 400,  32, 3, 276,  55, 1, 1, 0};
    vecs[5]  = '{1'b0, 320, 400,  95, 1, 260,  40, 1, 0, 0};
    vecs[6]  = '{1'b0, 320, 400,  96, 1, 266,  55, 1, 1, 0};
    vecs[7]  = '{1'b0, 320, 400, 122, 1, 314, 445, 1, 1, 0};
    vecs[8]  = '{1'b0, 320, 400, 123, 1, 316, 440, 1, 0, 0};
    vecs[9]  = '{1'b0, 320, 400, 127, 0, 260,  40, 1, 0, 0};
    vecs[10] = '{1'b0, 320, 400, 128, 0, 266,  55, 1, 1, 0};
    vecs[11] = '{1'b1,   0, 400, 127, 0,  60,  40, 1, 0, 0};
    vecs[12] = '{1'b0,   0, 400, 128, 0,  54,  55, 1, 1, 0};
    vecs[13] = '{1'b0,   0, 400, 136, 0,   6, 175, 1, 1, 0};
    vecs[14] = '{1'b0,   0, 400, 137, 0,   5, 190, 1, 1, 0};
    vecs[15] = '{1'b0,   0, 400, 140, 0,   5, 235, 1, 1, 0};

    player_x = 10'd320;
    player_y = 10'd400;
    apply_reset();
    check_reset("reset");

    for (int k = 0; k < 16; k++) begin
      if (vecs[k].rst) apply_reset();
      player_x = 10'(vecs[k].px);
      player_y = 10'(vecs[k].py);
      exp_q.push_back(vecs[k]);
      while (tcount < vecs[k].t) do_tick();
      cur = exp_q.pop_front();
      check($sformatf("v%0d_x%0d", k, cur.idx), ex_of(cur.idx), cur.ex);
      check($sformatf("v%0d_y%0d", k, cur.idx), ey_of(cur.idx), cur.ey);
      check($sformatf("v%0d_on%0d", k, cur.idx), int'(enemy_on[cur.idx]), cur.eon);
      check($sformatf("v%0d_div%0d", k, cur.idx), int'(diving[cur.idx]), cur.ediv);
      check($sformatf("v%0d_score", k), int'(score), cur.escore);
    end

    // Player death while enemy 0 is mid-dive.
    dead = 1'b1;
    @(posedge Clk); #1;
    dead = 1'b0;
    check_reset("dead");

    // Player death on the same cycle a tick is being applied.
    player_x = 10'd320;
    player_y = 10'd400;
    do_tick();
    check("pre_dt_x0", ex_of(0), 62);
    frame_clk = 1'b1;
    @(posedge Clk); #1;
    frame_clk = 1'b0;
    dead      = 1'b1;
    @(posedge Clk); #1;
    dead = 1'b0;
    check_reset("dead_tick");

    // Asynchronous reset between clock edges.
    do_tick();
    do_tick();
    do_tick();
    check("pre_async_x0", ex_of(0), 66);
    RESET_n = 1'b0;
    #2;
    check_reset("async");
    @(posedge Clk); #1;
    RESET_n = 1'b1;

    // Single kill, ignored hit while dead, respawn.
    apply_reset();
    player_x = 10'd320;
    player_y = 10'd400;
    pulse_hit(4'b0100);
    do_tick();
    check("kill2_on", int'(enemy_on), 11);
    check("kill2_score", int'(score), 1);
    pulse_hit(4'b0100);
    for (int i = 0; i < 119; i++) do_tick();
    check("dead2_on", int'(enemy_on), 11);
    check("dead2_score", int'(score), 1);
    do_tick();
    check("resp2_on", int'(enemy_on), 15);
    check("resp2_x", ex_of(2), 200);
    check("resp2_y", ey_of(2), 40);
    check("resp2_div", int'(diving[2]), 0);
    do_tick();
    check("post2_on", int'(enemy_on[2]), 1);
    check("post2_score", int'(score), 1);

    // Two kills latched on different cycles of one frame.
    pulse_hit(4'b0001);
    pulse_hit(4'b1000);
    do_tick();
    check("dual_score", int'(score), 3);
    check("dual_on", int'(enemy_on), 6);

    // Score saturation with every enemy hit continuously.
    apply_reset();
    hit = 4'b1111;
    for (int t = 1; t <= 7745; t++) begin
      do_tick();
      if (t == 1) begin
        check("sat_t1_score", int'(score), 4);
        check("sat_t1_on", int'(enemy_on), 0);
      end
      if (t == 121) begin
        check("sat_t121_score", int'(score), 4);
        check("sat_t121_on", int'(enemy_on), 15);
      end
      if (t == 122) begin
        check("sat_t122_score", int'(score), 8);
        check("sat_t122_on", int'(enemy_on), 0);
      end
      if (t == 7503) check("sat_t7503_score", int'(score), 252);
      if (t == 7624) check("sat_t7624_score", int'(score), 255);
      if (t == 7745) check("sat_t7745_score", int'(score), 255);
    end
    hit = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
